// File: rtl/port_bus_arbiter.sv
// port_bus_arbiter: shares the 8-bit port serial bus between NUM_REQ requesters.
// Round-robin arbitration, one single-byte frame per grant:
//   write: CMD -> WR -> ACK
//   read : CMD -> TURN -> RD -> ACK
// Every frame is followed by at least one IDLE cycle.
// port_rst is held high for RST_CYCLES cycles after reset release.
// Optional feature: define PORT_ARB_LOCK_EN to add req_lock. A locked owner that keeps
// requesting is regranted ahead of everyone else.

module port_bus_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [NUM_REQ*4-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0] req_wdata,
`ifdef PORT_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   req_lock,
`endif
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   ack,
   output logic [7:0]           rdata,
   output logic                 busy,
   output logic                 port_clk,
   output logic                 port_rst,
   inout  wire  [7:0]           data
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [IdxW-1:0] idx_t;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StCmd,
      StWr,
      StTurn,
      StRd,
      StAck
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   idx_t               rr_ptr_q, rr_ptr_d;
   idx_t               owner_q, owner_d;
   logic               we_q, we_d;
   logic [3:0]         addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;

   // Arbitration result for the current cycle
   logic               pick_valid;
   idx_t               pick_idx;
   logic               pick_we;
   logic [3:0]         pick_addr;
   logic [7:0]         pick_wdata;
   int unsigned        cand;

   logic               lock_hold;
   logic               data_oe;
   logic [7:0]         data_out;

   // Round-robin search: first requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_valid && req[cand[IdxW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IdxW-1:0];
         end
      end
   end

   // Mux out the winner's frame fields so they can be latched at grant
   always_comb begin
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == idx_t'(i)) begin
            pick_we    = req_we[i];
            pick_addr  = req_addr[4*i +: 4];
            pick_wdata = req_wdata[8*i +: 8];
         end
      end
   end

`ifdef PORT_ARB_LOCK_EN
   // gnt_q is one-hot during ACK, so this selects the owner's lock and request bits
   assign lock_hold = |(gnt_q & req_lock & req);
`else
   assign lock_hold = 1'b0;
`endif

   // Next-state logic for the frame sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      gnt_d    = gnt_q;

      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(RST_CYCLES - 1)) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (pick_valid) begin
               owner_d         = pick_idx;
               we_d            = pick_we;
               addr_d          = pick_addr;
               wdata_d         = pick_wdata;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               state_d         = StCmd;
            end
         end
         StCmd: begin
            state_d = we_q ? StWr : StTurn;
         end
         StWr: begin
            state_d = StAck;
         end
         StTurn: begin
            state_d = StRd;
         end
         StRd: begin
            rdata_d = data;
            state_d = StAck;
         end
         StAck: begin
            gnt_d   = '0;
            state_d = StIdle;
            if (lock_hold) begin
               // Pointing at the owner makes it the first candidate in the next IDLE
               rr_ptr_d = owner_q;
            end else if (owner_q == idx_t'(NUM_REQ - 1)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = owner_q + idx_t'(1);
            end
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StInit;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= 8'h00;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt_q    <= gnt_d;
      end
   end

   // Bus is driven only in CMD and WR; every other state leaves it released
   always_comb begin
      data_oe  = (state_q == StCmd) || (state_q == StWr);
      data_out = (state_q == StCmd) ? {we_q, 3'b000, addr_q} : wdata_q;
   end

   assign data     = data_oe ? data_out : 8'hzz;
   assign gnt      = gnt_q;
   assign ack      = (state_q == StAck) ? gnt_q : '0;
   assign rdata    = rdata_q;
   assign busy     = (state_q != StIdle);
   assign port_clk = clk;
   assign port_rst = (state_q == StInit);

`ifndef SYNTHESIS
   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
   a_ack_owned  : assert property (@(posedge clk) disable iff (!rst) (ack & ~gnt) == '0);
`endif

endmodule

// File: doc/port_bus_arbiter.md
Name: port_bus_arbiter

Overview:
- Shares the 8-bit port serial bus (port_clk, port_rst, data) between NUM_REQ requesters.
- Each requester asks for one single-byte read or write of a port address (0-15).
- The block round-robin arbitrates and sequences the bus frame (command, turnaround, data) for the winner.
- It returns an ack and, for reads, the sampled byte; it issues the port_rst pulse at start-up.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RST_CYCLES, 2, cycles port_rst stays high after reset release (1..15).

Ports:
- clk  input  1  system clock; port_clk is driven from it.
- rst  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; hold high until ack.
- req_we  input  NUM_REQ  1 = write to port, 0 = read from port.
- req_addr  input  NUM_REQ*4  port address, requester i at bits [4i+3:4i].
- req_wdata  input  NUM_REQ*8  write byte, requester i at bits [8i+7:8i].
- gnt  output  NUM_REQ  one-hot; high from CMD through ACK of the owning frame.
- ack  output  NUM_REQ  one-cycle pulse in the ACK state.
- rdata  output  8  last read byte; valid in the ACK cycle of a read, held until the next read.
- busy  output  1  high in every state except IDLE.
- port_clk  output  1  equals clk.
- port_rst  output  1  port-side reset.
- data  inout  8  shared port bus; driven only while data_oe is internally high, else 8'hzz.

Behaviour:
- Reset: sampled low at posedge -> state INIT, cnt=0, rr_ptr=0, gnt=0, ack=0, rdata=8'h00, busy=1, port_rst=1, bus released (z).
  - Reset mid-frame aborts the frame with no ack.
- INIT: port_rst=1. cnt increments each cycle with rst high; on cnt==RST_CYCLES-1 go to IDLE with port_rst=0.
  - port_rst is high for exactly RST_CYCLES cycles after rst deasserts.
- IDLE: bus z, busy=0. If any req is high, choose the first requester at or after rr_ptr (modulo NUM_REQ).
  - Latch its we, addr and wdata into frame registers; set gnt; go to CMD.
  - If no req is high, stay in IDLE.
- CMD: drive command byte {we,3'b000,addr}.
  - we=1 -> WR.
  - we=0 -> TURN.
- WR: drive latched wdata; go to ACK.
- TURN: bus z for one cycle (turnaround); go to RD.
- RD: bus z; at the end of the cycle capture rdata<=data; go to ACK.
- ACK: bus z, ack[i]=1, gnt still high; rr_ptr<=i+1 (wrap to 0 after NUM_REQ-1); go to IDLE, clearing gnt.
- Latency from grant (first CMD cycle) to ack:
  - write: ack in the 3rd cycle;
  - read: ack in the 4th cycle.
- Frames are always separated by at least one IDLE cycle.
- Inputs are latched at grant; later changes to req_we/addr/wdata, or dropping req, do not affect the frame in flight.
- A requester whose req is still high in the IDLE cycle after its ACK is treated as a new request. It loses priority to any other pending requester.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep waiting.
  - Starvation bound: NUM_REQ-1 frames.
- The bus is never driven by the block in INIT, IDLE, TURN, RD or ACK.

Optional Feature:
- Macro PORT_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (NUM_REQ bits).
  - If the granted requester has req_lock[i]=1 and req[i]=1 in its ACK cycle, rr_ptr is not advanced and the next IDLE regrants i ahead of others.
  - Other requesters wait until lock drops.
- Undefined:
  - No req_lock port.
  - Pure round-robin as above.

Test Plan:
- Reset release with RST_CYCLES=2 -> port_rst high exactly 2 cycles after rst goes high; busy low in the 3rd cycle; gnt=0, rdata=8'h00.
- Requester 1 writes addr 4'h5, byte 8'hA7:
  - data shows 8'h85 then 8'hA7 on consecutive cycles;
  - ack[1] pulses in the following cycle;
  - then bus z.
- Requester 2 reads addr 4'h3, bus model drives 8'h5C in the RD cycle:
  - CMD byte 8'h03, then one z turnaround cycle;
  - ack[2] with rdata=8'h5C in the 4th cycle after grant.
- All four req high continuously, rr_ptr=0 -> grant order 0,1,2,3,0; exactly one IDLE cycle between frames; gnt always one-hot.
- rst driven low during the WR cycle -> next cycle: bus z, gnt=0, no ack, port_rst=1; after release, the INIT sequence repeats.
- With PORT_ARB_LOCK_EN, req_lock[0]=1 and req 0 and 1 both pending -> requester 0 granted three frames in a row; requester 1 granted on the first frame after lock drops.
